// File: rtl/piezo_sched_pkg.sv
// Shared types, widths and helpers for the piezo slot scheduler.
package piezo_sched_pkg;

  localparam int IDX_W         = 6;
  localparam int HP_W          = 16;
  localparam int TALLY_W       = 17;
  localparam int NUM_PIEZO_DEF = 61;
  localparam int CNT_W_DEF     = 24;
  localparam int TIME_W_DEF    = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEEK  = 3'd1,
    ST_BURST = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [31:0] max1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/piezo_slot_scheduler_if.sv
// Config, time and emitter-drive signals between the scheduler and its system.
interface piezo_slot_scheduler_if
  import piezo_sched_pkg::*;
#(
  parameter int NUM_PIEZO = NUM_PIEZO_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TIME_W    = TIME_W_DEF
);
  logic                 trigger_in;
  logic                 abort;
  logic [NUM_PIEZO-1:0] enable_mask;
  logic [HP_W-1:0]      half_period;
  logic [HP_W-1:0]      burst_cycles;
  logic [CNT_W-1:0]     gap_cycles;
  logic [TIME_W-1:0]    time_now;
  logic [NUM_PIEZO-1:0] piezo_out;
  logic                 piezo_enable;
  logic [2:0]           status;
  logic                 busy;
  logic [IDX_W-1:0]     slot_index;
  logic [TIME_W-1:0]    slot_time;
  logic                 slot_valid;
  logic                 done;
  logic                 missed_trigger;

  modport master (
    output trigger_in, abort, enable_mask, half_period, burst_cycles, gap_cycles, time_now,
    input  piezo_out, piezo_enable, status, busy, slot_index, slot_time, slot_valid, done,
           missed_trigger
  );

  modport slave (
    input  trigger_in, abort, enable_mask, half_period, burst_cycles, gap_cycles, time_now,
    output piezo_out, piezo_enable, status, busy, slot_index, slot_time, slot_valid, done,
           missed_trigger
  );
endinterface

// File: rtl/piezo_slot_scheduler_trig_sync_edge.sv
// Two-flop synchroniser for an asynchronous trigger plus a registered rising-edge pulse.
module trig_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic edge_o
);
  logic meta_q, sync_q, prev_q, edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      edge_q <= sync_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;
endmodule

// File: rtl/piezo_slot_scheduler.sv
// Fires each enabled piezo emitter in turn with a square-wave burst and silent gap,
// timestamping every slot start from the PTP time bus.
module piezo_slot_scheduler
  import piezo_sched_pkg::*;
#(
  parameter int NUM_PIEZO = NUM_PIEZO_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TIME_W    = TIME_W_DEF
)(
  input logic clk,
  input logic reset,
  piezo_slot_scheduler_if.slave bus
);
  // One extra index bit so the scan can reach NUM_PIEZO (up to 64).
  localparam int IW = IDX_W + 1;

  logic                 trig_edge;
  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_PIEZO-1:0] mask_q, mask_d;
  logic [HP_W-1:0]      hp_q, hp_d, bc_q, bc_d, hp_cnt_q, hp_cnt_d;
  logic [TALLY_W-1:0]   tally_q, tally_d;
  logic [CNT_W-1:0]     gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic                 phase_q, phase_d;
  logic [IDX_W-1:0]     sidx_q, sidx_d;
  logic [TIME_W-1:0]    stime_q, stime_d;
  logic                 sv_q, sv_d, done_q, done_d, miss_q, miss_d;
  logic [NUM_PIEZO-1:0] sel_oh;
  logic                 sel_en, hp_end, burst_end, gap_end;

  trig_sync_edge u_trig (
    .clk     (clk),
    .reset   (reset),
    .async_i (bus.trigger_in),
    .edge_o  (trig_edge)
  );

  assign sel_oh    = NUM_PIEZO'(1) << idx_q;
  assign sel_en    = |(mask_q & sel_oh);
  assign hp_end    = (32'(hp_cnt_q) == max1(32'(hp_q)) - 32'd1);
  assign burst_end = hp_end && (32'(tally_q) + 32'd1 == (max1(32'(bc_q)) << 1));
  assign gap_end   = (32'(gap_cnt_q) == max1(32'(gap_q)) - 32'd1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    hp_d      = hp_q;
    bc_d      = bc_q;
    gap_d     = gap_q;
    hp_cnt_d  = hp_cnt_q;
    tally_d   = tally_q;
    gap_cnt_d = gap_cnt_q;
    phase_d   = phase_q;
    sidx_d    = sidx_q;
    stime_d   = stime_q;
    sv_d      = 1'b0;
    done_d    = 1'b0;
    miss_d    = trig_edge && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (trig_edge) begin
          mask_d  = bus.enable_mask;
          hp_d    = bus.half_period;
          bc_d    = bus.burst_cycles;
          gap_d   = bus.gap_cycles;
          idx_d   = '0;
          state_d = ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (idx_q == IW'(NUM_PIEZO)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (sel_en) begin
          state_d  = ST_BURST;
          phase_d  = 1'b1;
          hp_cnt_d = '0;
          tally_d  = '0;
          sv_d     = 1'b1;
          sidx_d   = idx_q[IDX_W-1:0];
          stime_d  = bus.time_now;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_BURST: begin
        if (hp_end) begin
          hp_cnt_d = '0;
          phase_d  = ~phase_q;
          tally_d  = tally_q + TALLY_W'(1);
          if (burst_end) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
            phase_d   = 1'b0;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + HP_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          state_d = ST_SEEK;
          idx_d   = idx_q + IW'(1);
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a trigger arriving in the same cycle.
    if (bus.abort) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      hp_cnt_d  = '0;
      tally_d   = '0;
      gap_cnt_d = '0;
      phase_d   = 1'b0;
      sv_d      = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      hp_q      <= '0;
      bc_q      <= '0;
      gap_q     <= '0;
      hp_cnt_q  <= '0;
      tally_q   <= '0;
      gap_cnt_q <= '0;
      phase_q   <= 1'b0;
      sidx_q    <= '0;
      stime_q   <= '0;
      sv_q      <= 1'b0;
      done_q    <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      hp_q      <= hp_d;
      bc_q      <= bc_d;
      gap_q     <= gap_d;
      hp_cnt_q  <= hp_cnt_d;
      tally_q   <= tally_d;
      gap_cnt_q <= gap_cnt_d;
      phase_q   <= phase_d;
      sidx_q    <= sidx_d;
      stime_q   <= stime_d;
      sv_q      <= sv_d;
      done_q    <= done_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.piezo_out      = (state_q == ST_BURST && phase_q) ? sel_oh : '0;
  assign bus.piezo_enable   = (state_q != ST_IDLE);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.status         = state_q;
  assign bus.slot_index     = sidx_q;
  assign bus.slot_time      = stime_q;
  assign bus.slot_valid     = sv_q;
  assign bus.done           = done_q;
  assign bus.missed_trigger = miss_q;
endmodule

// File: tb/tb_piezo_slot_scheduler.sv
// Bench for piezo_slot_scheduler: per-cycle expected trace built from the slot rules.
module tb_piezo_slot_scheduler;
  import piezo_sched_pkg::*;

  localparam int NP   = NUM_PIEZO_DEF;
  localparam int CW   = CNT_W_DEF;
  localparam int TW   = TIME_W_DEF;
  localparam int MAXC = 8192;

  typedef struct {
    logic [2:0]    st;
    logic [NP-1:0] po;
    logic          sv;
    logic [5:0]    si;
    logic [TW-1:0] stime;
    logic          dn;
    logic          mt;
    logic          clr;
  } rec_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  int            cyc   = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            chk_on = 1'b0;
  logic [5:0]    held_si = '0;
  logic [TW-1:0] held_st = '0;
  rec_t          cur;
  rec_t          exp_tab [MAXC];

  piezo_slot_scheduler_if #(.NUM_PIEZO(NP), .CNT_W(CW), .TIME_W(TW)) bus ();

  piezo_slot_scheduler #(.NUM_PIEZO(NP), .CNT_W(CW), .TIME_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PTP time equals the number of clock edges seen so far.
  initial begin
    bus.time_now = '0;
    forever begin
      @(negedge clk);
      bus.time_now = TW'(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, want);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r.st = 3'd0; r.po = '0; r.sv = 1'b0; r.si = '0;
    r.stime = '0; r.dn = 1'b0; r.mt = 1'b0; r.clr = 1'b0;
    return r;
  endfunction

  task automatic put(input int k, input rec_t r);
    if (k >= 0 && k < MAXC) exp_tab[k] = r;
  endtask

  task automatic clear_from(input int a, input int b);
    for (int k = a; k < b; k++) put(k, idle_rec());
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Expected trace of a round whose first SEEK cycle is s; e is the first idle cycle after it.
  task automatic build_round(input int s, input logic [NP-1:0] mask, input int hp, input int bc,
                             input int gap, output int e);
    rec_t          r;
    int            k;
    int            hpv, bcv, gv;
    logic [NP-1:0] sh;
    hpv = (hp == 0) ? 1 : hp;
    bcv = (bc == 0) ? 1 : bc;
    gv  = (gap == 0) ? 1 : gap;
    k   = s;
    for (int idx = 0; idx <= NP; idx++) begin
      r = idle_rec(); r.st = 3'd1; put(k, r); k++;
      sh = mask >> idx;
      if (idx == NP) begin
        r = idle_rec(); r.st = 3'd4; r.dn = 1'b1; put(k, r); k++;
      end else if (sh[0]) begin
        for (int j = 0; j < 2 * hpv * bcv; j++) begin
          r = idle_rec();
          r.st    = 3'd2;
          r.po    = (((j / hpv) % 2) == 0) ? (NP'(1) << idx) : '0;
          r.sv    = (j == 0);
          r.si    = 6'(idx);
          r.stime = TW'(k - 1);
          put(k, r); k++;
        end
        for (int g = 0; g < gv; g++) begin
          r = idle_rec(); r.st = 3'd3; put(k, r); k++;
        end
      end
    end
    e = k;
  endtask

  task automatic start_round(input logic [NP-1:0] mask, input int hp, input int bc, input int gap,
                             output int s, output int e);
    bus.enable_mask  = mask;
    bus.half_period  = 16'(hp);
    bus.burst_cycles = 16'(bc);
    bus.gap_cycles   = CW'(gap);
    bus.trigger_in   = 1'b1;
    s = cyc + 4;
    build_round(s, mask, hp, bc, gap, e);
    repeat (4) @(negedge clk);
    bus.trigger_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      cur = exp_tab[cyc];
      if (cur.clr) begin held_si = '0; held_st = '0; end
      if (cur.sv)  begin held_si = cur.si; held_st = cur.stime; end
      check_val("status",     64'(bus.status),         64'(cur.st));
      check_val("piezo_out",  64'(bus.piezo_out),      64'(cur.po));
      check_val("onehot",     64'($countones(bus.piezo_out) <= 1), 64'(1));
      check_val("busy",       64'(bus.busy),           64'(cur.st != 3'd0));
      check_val("enable",     64'(bus.piezo_enable),   64'(cur.st != 3'd0));
      check_val("slot_valid", 64'(bus.slot_valid),     64'(cur.sv));
      check_val("slot_index", 64'(bus.slot_index),     64'(held_si));
      check_val("slot_time",  64'(bus.slot_time),      64'(held_st));
      check_val("done",       64'(bus.done),           64'(cur.dn));
      check_val("missed",     64'(bus.missed_trigger), 64'(cur.mt));
    end
  end

  initial begin
    int            s, e, ca, cr;
    logic [63:0]   r64;
    logic [NP-1:0] m;
    for (int i = 0; i < MAXC; i++) exp_tab[i] = idle_rec();
    bus.trigger_in   = 1'b0;
    bus.abort        = 1'b0;
    bus.enable_mask  = '0;
    bus.half_period  = '0;
    bus.burst_cycles = '0;
    bus.gap_cycles   = '0;
    chk_on = 1'b1;
    wait_until(3);
    reset = 1'b0;

    // Single emitter: trigger first sampled at edge 10, slot_valid after edge 19.
    wait_until(9);
    start_round(NP'(1) << 5, 4, 2, 3, s, e);
    wait_until(e + 2);

    start_round((NP'(1) << 0) | (NP'(1) << 1) | (NP'(1) << 60), 1, 1, 0, s, e);
    wait_until(e + 2);

    start_round(NP'(1), 0, 0, 2, s, e);
    wait_until(e + 2);

    start_round('0, 2, 2, 1, s, e);
    wait_until(e + 3);

    // Second trigger during the first burst plus new config mid-round.
    start_round((NP'(1) << 2) | (NP'(1) << 10), 3, 3, 2, s, e);
    wait_until(s + 4);
    bus.half_period  = 16'd9;
    bus.burst_cycles = 16'd7;
    bus.gap_cycles   = CW'(11);
    bus.enable_mask  = '1;
    bus.trigger_in   = 1'b1;
    exp_tab[s + 8].mt = 1'b1;
    repeat (4) @(negedge clk);
    bus.trigger_in = 1'b0;
    wait_until(e + 2);

    // Abort while emitter 7 is in a high half-period (burst starts at s+8, hp=2).
    start_round((NP'(1) << 7) | (NP'(1) << 20), 2, 2, 1, s, e);
    ca = s + 12;
    wait_until(ca);
    bus.abort = 1'b1;
    clear_from(ca + 1, e);
    @(negedge clk);
    bus.abort = 1'b0;
    wait_until(ca + 4);
    start_round(NP'(1) << 3, 1, 2, 0, s, e);
    wait_until(e + 2);

    // Reset in the middle of emitter 4's gap (gap spans s+7..s+9).
    start_round((NP'(1) << 4) | (NP'(1) << 9), 1, 1, 3, s, e);
    cr = s + 8;
    wait_until(cr);
    reset = 1'b1;
    clear_from(cr + 1, e);
    exp_tab[cr + 1].clr = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_until(cr + 4);
    start_round(NP'(1) << 1, 2, 1, 1, s, e);
    wait_until(e + 2);

    for (int r = 0; r < 6; r++) begin
      if (cyc > MAXC - 1200) break;
      r64 = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      m   = r64[NP-1:0];
      start_round(m, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), s, e);
      wait_until(e + int'($urandom_range(2, 5)));
    end

    wait_until(cyc + 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/piezo_slot_scheduler.md
Name: piezo_slot_scheduler

Overview:
Sequences the piezo emitter bank for one localisation round. On each RTC event trigger it drives every enabled emitter in turn with a square-wave burst, followed by a configurable silent gap. It timestamps each slot start from the PTP time bus so the triangulation software can match received bursts to emitters. It sits between the RTC/PTP blocks and the piezo output pins, alongside the piezo controller.

Parameters:
NUM_PIEZO, 61, number of emitter outputs (max 64)
CNT_W, 24, width of gap counter
TIME_W, 32, width of PTP time bus / slot timestamp

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
trigger_in  in  1  RTC event trigger, asynchronous to clk
abort  in  1  synchronous abort request, level
enable_mask  in  NUM_PIEZO  emitters to fire this round
half_period  in  16  burst half-period in clk cycles
burst_cycles  in  16  full square-wave periods per burst
gap_cycles  in  CNT_W  silent cycles after each burst
time_now  in  TIME_W  current PTP time
piezo_out  out  NUM_PIEZO  emitter drive, at most one bit active
piezo_enable  out  1  amplifier enable
status  out  3  state code from package
busy  out  1  round in progress
slot_index  out  6  index of current/last fired emitter
slot_time  out  TIME_W  time_now captured at slot start
slot_valid  out  1  one-cycle pulse when slot_index/slot_time update
done  out  1  one-cycle pulse at round end
missed_trigger  out  1  one-cycle pulse when a trigger edge arrives while busy

Behaviour:
- Reset values: all outputs 0. status=IDLE. Internal index and counters 0. Shadow config 0.
- trigger_in passes through a 2-flop synchroniser plus rising-edge detect. trig_edge is asserted in the 3rd clk after trigger_in rises.
- States and codes: IDLE=0, SEEK=1, BURST=2, GAP=3, DONE=4.
- IDLE:
  - On trig_edge: latch enable_mask, half_period, burst_cycles and gap_cycles into shadow registers; idx<=0; go to SEEK.
  - Input config changes during a round have no effect.
- SEEK: scans one index per cycle.
  - idx==NUM_PIEZO -> DONE.
  - mask_l[idx]=1 -> BURST. In the same cycle: slot_time<=time_now, slot_index<=idx, slot_valid pulses.
  - Otherwise idx<=idx+1.
  - An all-zero mask takes NUM_PIEZO+1 SEEK cycles, then DONE.
- BURST:
  - piezo_out[idx]=phase. All other bits are 0.
  - phase is 1 in the first BURST cycle and toggles every hp cycles, where hp = max(half_period,1).
  - After 2*max(burst_cycles,1) half-periods, go to GAP.
  - BURST length is exactly 2*hp*bc cycles.
- GAP:
  - piezo_out=0. Counts gap_cycles cycles, then SEEK with idx+1.
  - gap_cycles=0 gives one transit cycle: GAP then SEEK.
- DONE: one cycle. done pulses, then IDLE.
- piezo_enable=1 and busy=1 in every state except IDLE.
- trig_edge while not IDLE: missed_trigger pulses and the round is unaffected.
- abort=1 in any state: next cycle goes to IDLE with piezo_out=0, counters cleared, no done pulse. abort has priority over trig_edge in the same cycle.
- slot_index and slot_time hold their last value until the next slot_valid.
- Reset mid-burst: piezo_out goes to 0 on the next clk edge.
- Counters:
  - Half-period counter is 16 bit.
  - Half-period tally is 17 bit, so burst_cycles=65535 does not overflow.
  - No wrap-around is permitted within a round.

Decomposition:
- Package piezo_sched_pkg holds:
  - state enum with the status codes above
  - IDX_W=6
  - default widths
  - helper function max1(x) returning x==0 ? 1 : x
- Sub-module trig_sync_edge: 2-flop synchroniser plus rising-edge pulse, reused for rtc_0 event_trigger2.

Test Plan:
- Single emitter:
  - Stimulus: mask=bit5, hp=4, bc=2, gap=3, time_now=cycle count; trigger rises at cycle 10.
  - Response: trig_edge at cycle 13. slot_valid at cycle 19 with slot_index=5 (SEEK idx 0..5). piezo_out[5] toggles as 1111000011110000 over 16 cycles, then 3 gap cycles. done pulses; busy=0 afterwards.
- Multi-emitter:
  - Stimulus: mask={0,1,60}, hp=1, bc=1, gap=0.
  - Response: three slot_valid pulses with indices 0, 1, 60. slot_time values strictly increasing. Never more than one piezo_out bit high.
- Zero config:
  - Stimulus: hp=0, bc=0, mask=bit0.
  - Response: burst behaves as hp=1, bc=1, i.e. 2 BURST cycles, pattern 1 then 0.
- Empty mask:
  - Stimulus: mask=0, trigger.
  - Response: no slot_valid. done pulses 62 SEEK cycles after trig_edge.
- Re-trigger and config change:
  - Stimulus: second trigger edge during BURST; change hp mid-round.
  - Response: missed_trigger pulses once, round timing unchanged, shadow hp is used.
- Abort and reset:
  - Stimulus: abort during BURST at phase=1; separately, reset during GAP.
  - Response: next cycle piezo_out=0, status=IDLE, no done pulse, busy=0. A new trigger starts a fresh round from idx 0.
